// File: rtl/mem_arbiter.sv
// mem_arbiter: data-priority arbiter for a shared single-port memory.
// Fetch is forced through after MAX_WAIT consecutive denials so it cannot starve.
module mem_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10,
    parameter int MAX_WAIT  = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 i_req,
    input  logic [ADDR_SIZE-1:0] i_addr,
    output logic [DATA_SIZE-1:0] i_rdata,
    output logic                 i_valid,
    output logic                 i_stall,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_SIZE-1:0] d_addr,
    input  logic [DATA_SIZE-1:0] d_wdata,
    output logic [DATA_SIZE-1:0] d_rdata,
    output logic                 d_valid,
    output logic                 d_stall,
    output logic [ADDR_SIZE-1:0] m_addr,
    output logic [DATA_SIZE-1:0] m_wdata,
    output logic                 m_we,
    output logic                 m_re,
    input  logic [DATA_SIZE-1:0] m_rdata,
    output logic [15:0]          conflict_cnt
);
    localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    typedef enum logic [1:0] {RESP_NONE, RESP_I, RESP_D} resp_t;

    resp_t         state, state_nxt;
    logic [WW-1:0] wait_cnt;
    logic          force_i, gnt_i, gnt_d;

    always_comb begin
        force_i   = i_req && wait_cnt == WMAX;
        gnt_d     = RESET_N && d_req && !force_i;
        gnt_i     = RESET_N && i_req && !gnt_d;
        m_addr    = gnt_d ? d_addr : gnt_i ? i_addr : '0;
        m_wdata   = gnt_d ? d_wdata : '0;
        m_we      = gnt_d && d_we;
        m_re      = gnt_i || (gnt_d && !d_we);
        i_stall   = i_req && !gnt_i;
        d_stall   = d_req && !gnt_d;
        state_nxt = gnt_i ? RESP_I : (gnt_d && !d_we) ? RESP_D : RESP_NONE;
        i_valid   = state == RESP_I;
        d_valid   = state == RESP_D;
        i_rdata   = i_valid ? m_rdata : '0;
        d_rdata   = d_valid ? m_rdata : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state        <= RESP_NONE;
            wait_cnt     <= '0;
            conflict_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!i_req || gnt_i)
                wait_cnt <= '0;
            else if (gnt_d && wait_cnt != WMAX)
                wait_cnt <= wait_cnt + WW'(1);
            if (i_req && d_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a cycle-level reference model.
module tb_mem_arbiter;
    localparam int MAX_WAIT = 4;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [9:0]  i_addr = '0, d_addr = '0, m_addr;
    logic [31:0] d_wdata = '0, i_rdata, d_rdata, m_wdata, m_rdata = '0;
    logic        i_valid, i_stall, d_valid, d_stall, m_we, m_re;
    logic [15:0] conflict_cnt;

    logic [31:0] mem [1024];
    int vectors = 0, errors = 0;
    int w = 0, cc = 0, pk = 0;
    logic [31:0] pd = '0;

    mem_arbiter #(.DATA_SIZE(32), .ADDR_SIZE(10), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re), .m_rdata(m_rdata),
        .conflict_cnt(conflict_cnt)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (m_we) mem[m_addr] <= m_wdata;
        if (m_re) m_rdata <= mem[m_addr];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step(input logic rn, input logic ir, input logic [9:0] ia,
                        input logic dr, input logic dwe, input logic [9:0] da, input logic [31:0] dwd);
        logic gi, gd;
        @(negedge CLK);
        RESET_N = rn; i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        #1;
        gd = rn && dr && !(ir && w == MAX_WAIT);
        gi = rn && ir && !gd;
        check("m_addr", 32'(m_addr), gd ? 32'(da) : gi ? 32'(ia) : 32'h0);
        check("m_wdata", m_wdata, gd ? dwd : 32'h0);
        check("m_re", 32'(m_re), 32'(gi || (gd && !dwe)));
        check("m_we", 32'(m_we), 32'(gd && dwe));
        check("i_stall", 32'(i_stall), 32'(ir && !gi));
        check("d_stall", 32'(d_stall), 32'(dr && !gd));
        check("i_valid", 32'(i_valid), 32'(pk == 1));
        check("i_rdata", i_rdata, pk == 1 ? pd : 32'h0);
        check("d_valid", 32'(d_valid), 32'(pk == 2));
        check("d_rdata", d_rdata, pk == 2 ? pd : 32'h0);
        check("conflict_cnt", 32'(conflict_cnt), 32'(cc));
        if (!rn) begin
            w = 0; cc = 0; pk = 0;
        end else begin
            w  = (!ir || gi) ? 0 : (w < MAX_WAIT ? w + 1 : w);
            cc = (ir && dr && cc < 65535) ? cc + 1 : cc;
            pd = mem[gi ? ia : da];
            pk = gi ? 1 : (gd && !dwe) ? 2 : 0;
        end
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 10'd1, 1, 1, 10'd2, 32'h5);
        check("rst_m_we", 32'(m_we), 32'h0);
        check("rst_i_stall", 32'(i_stall), 32'h1);
        idle();
        check("rst_cnt", 32'(conflict_cnt), 32'h0);
        // memory word 5 seeded through a data write, then fetched
        step(1, 0, 0, 1, 1, 10'd5, 32'hDEADBEEF);
        step(1, 1, 10'd5, 0, 0, 0, 0);
        check("fetch_re", 32'(m_re), 32'h1);
        check("fetch_addr", 32'(m_addr), 32'd5);
        idle();
        check("fetch_valid", 32'(i_valid), 32'h1);
        check("fetch_rdata", i_rdata, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 10'd9, 1, 0, 10'd7, 0);
        check("conf_i_stall", 32'(i_stall), 32'h1);
        check("conf_d_stall", 32'(d_stall), 32'h0);
        check("conf_addr", 32'(m_addr), 32'd7);
        idle();
        check("conf_d_valid", 32'(d_valid), 32'h1);
        check("conf_i_valid", 32'(i_valid), 32'h0);
        check("conf_cnt", 32'(conflict_cnt), 32'h1);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            step(1, 1, 10'd20, 1, 0, 10'd20, 0);
            check("starve_i_stall", 32'(i_stall), 32'(k % 5 != 4));
            check("starve_d_stall", 32'(d_stall), 32'(k % 5 == 4));
        end
        step(1, 0, 0, 1, 1, 10'd3, 32'h12345678);
        check("wr_we", 32'(m_we), 32'h1);
        check("wr_re", 32'(m_re), 32'h0);
        check("wr_addr", 32'(m_addr), 32'd3);
        check("wr_wdata", m_wdata, 32'h12345678);
        step(1, 0, 0, 1, 0, 10'd3, 0);
        check("wr_no_valid", 32'(d_valid), 32'h0);
        idle();
        check("rd_back", d_rdata, 32'h12345678);
        step(1, 1, 10'd3, 1, 0, 10'd4, 0);
        step(1, 1, 10'd3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        idle();
        check("rst_mid_valid", 32'(i_valid), 32'h0);
        check("rst_mid_cnt", 32'(conflict_cnt), 32'h0);
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 99) != 0, 1'($urandom), 10'($urandom_range(0, 15)),
                 1'($urandom), 1'($urandom), 10'($urandom_range(0, 15)), $urandom);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 65534; k++)
            step(1, 1, 10'($urandom_range(0, 15)), 1, 1'($urandom), 10'($urandom_range(0, 15)), $urandom);
        idle();
        check("sat_fffe", 32'(conflict_cnt), 32'h0000FFFE);
        step(1, 1, 10'd1, 1, 0, 10'd2, 0);
        step(1, 1, 10'd1, 1, 0, 10'd2, 0);
        idle();
        check("sat_ffff", 32'(conflict_cnt), 32'h0000FFFF);
        step(1, 1, 10'd1, 1, 1, 10'd2, 32'h1);
        idle();
        check("sat_hold", 32'(conflict_cnt), 32'h0000FFFF);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, memory word width.
REQ-002 SHALL have parameter ADDR_SIZE, default 10, word address width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, maximum consecutive fetch denials before forced fetch grant.
REQ-004 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port RESET_N  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-006 SHALL have ports i_req input 1, i_addr input ADDR_SIZE: instruction-fetch read request and address.
REQ-007 SHALL have ports i_rdata output DATA_SIZE, i_valid output 1, i_stall output 1: fetch read data, fetch data valid, fetch not granted this cycle.
REQ-008 SHALL have ports d_req input 1, d_we input 1, d_addr input ADDR_SIZE, d_wdata input DATA_SIZE: data-port request (d_we=1 write, d_we=0 read), address and write data.
REQ-009 SHALL have ports d_rdata output DATA_SIZE, d_valid output 1, d_stall output 1: data-port read data, read data valid, data port not granted this cycle.
REQ-010 SHALL have ports m_addr output ADDR_SIZE, m_wdata output DATA_SIZE, m_we output 1, m_re output 1, m_rdata input DATA_SIZE: shared single-port memory; read data appears on m_rdata the cycle after m_re=1.
REQ-011 SHALL have port conflict_cnt  output 16  saturating count of cycles with i_req=1 and d_req=1.

Function
REQ-012 SHALL grant at most one requester per cycle; grant is combinational from current inputs and registered state.
REQ-013 SHALL grant D when d_req=1 and not force_i; else SHALL grant I when i_req=1; else no grant.
REQ-014 SHALL define force_i = i_req=1 and wait_cnt==MAX_WAIT; force_i overrides d_req.
REQ-015 wait_cnt (width clog2(MAX_WAIT+1)) SHALL increment when i_req=1 and D granted, saturate at MAX_WAIT, and clear when I granted or i_req=0.
REQ-016 SHALL drive m_addr/m_wdata from the granted requester; m_addr=0, m_wdata=0 when no grant.
REQ-017 SHALL assert m_re=1 for an I grant or a D grant with d_we=0; m_we=1 only for a D grant with d_we=1; m_re and m_we never both 1.
REQ-018 SHALL assert i_stall = i_req and not I-granted; d_stall = d_req and not D-granted; both combinational.
REQ-019 SHALL track pending read responses with FSM states RESP_NONE, RESP_I, RESP_D; next state RESP_I after an I grant, RESP_D after a D read grant, RESP_NONE otherwise (including D write grant or no grant).
REQ-020 In RESP_I SHALL assert i_valid=1, i_rdata=m_rdata; in RESP_D SHALL assert d_valid=1, d_rdata=m_rdata; non-valid rdata outputs SHALL be 0.
REQ-021 Read latency SHALL be exactly 1 cycle from grant to valid; back-to-back grants SHALL allow one completed read per cycle.
REQ-022 Write SHALL complete in its grant cycle; d_valid SHALL NOT assert for writes.
REQ-023 Requester de-asserting req while stalled SHALL abandon the request with no memory access.
REQ-024 Identical i_addr and d_addr in the same cycle SHALL still be serialized per REQ-013.
REQ-025 conflict_cnt SHALL increment each cycle with i_req=1 and d_req=1, saturating at 16'hFFFF.

Reset
REQ-026 With RESET_N=0 at a rising edge: FSM to RESP_NONE, wait_cnt=0, conflict_cnt=0; next cycle i_valid=0, d_valid=0, i_rdata=0, d_rdata=0.
REQ-027 Reset during a pending read SHALL discard the response; no valid pulse after reset.
REQ-028 While RESET_N=0 SHALL force m_re=0, m_we=0, i_stall=i_req, d_stall=d_req.

Verification
REQ-029 Fetch only: i_req=1, i_addr=5, memory[5]=32'hDEADBEEF -> m_re=1, m_addr=5 same cycle; next cycle i_valid=1, i_rdata=32'hDEADBEEF.
REQ-030 Conflict: i_req=1, d_req=1, d_we=0, d_addr=7 for one cycle -> d granted, i_stall=1, d_stall=0, m_addr=7; next cycle d_valid=1, i_valid=0; conflict_cnt=1.
REQ-031 Starvation: i_req=1, d_req=1 held continuously, MAX_WAIT=4 -> D granted cycles 0-3, I forced in cycle 4 (i_stall=0, d_stall=1), D again in cycle 5; pattern repeats every 5 cycles.
REQ-032 Write: d_req=1, d_we=1, d_addr=3, d_wdata=32'h12345678 -> m_we=1, m_re=0, m_addr=3, m_wdata=32'h12345678; next cycle d_valid=0; subsequent d read of address 3 returns 32'h12345678.
REQ-033 Reset mid-read: I read granted, RESET_N=0 on following edge -> i_valid=0, wait_cnt=0, conflict_cnt=0.
REQ-034 Saturation: force conflict_cnt to 16'hFFFE, two further conflict cycles -> conflict_cnt=16'hFFFF, no wrap to 0.
